// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_BURST_LEN  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = $clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_idx
);

  logic [IDX_W-1:0] w_cand;

  // Scan from farthest to nearest so the nearest hit after i_last wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      w_cand = IDX_W'((k + 32'(i_last)) % NUM_REQ);
      if (i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter feeding a FIFO write port with zero-latency writes.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned BURST_LEN  = DEF_BURST_LEN,
  localparam int unsigned IDX_W     = $clog2(NUM_REQ),
  localparam int unsigned CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic                          clk_write,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            Req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_data,
  output logic [NUM_REQ-1:0]            Req_ready,
  input  logic                          Full,
  output logic                          Wr_enable,
  output logic [DATA_WIDTH-1:0]         DataIn,
  output logic [IDX_W-1:0]              Grant_id,
  output logic                          Busy
);

  arb_state_e       r_state;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] r_last_owner;
  logic [CNT_W-1:0] r_count;

  logic                  w_found;
  logic [IDX_W-1:0]      w_pick;
  logic                  w_owner_valid;
  logic [DATA_WIDTH-1:0] w_owner_data;
  logic                  w_busy;
  logic                  w_xfer;
  logic [CNT_W-1:0]      w_count_inc;
  logic                  w_last_beat;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req   (Req_valid),
    .i_last  (r_last_owner),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  // Select the current owner's valid flag and data word.
  always_comb begin
    w_owner_valid = 1'b0;
    w_owner_data  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (r_owner == IDX_W'(k)) begin
        w_owner_valid = Req_valid[k];
        w_owner_data  = Req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_busy      = (r_state == BURST);
  assign w_xfer      = w_busy & w_owner_valid & ~Full;
  assign w_count_inc = r_count + CNT_W'(1);
  assign w_last_beat = (w_count_inc == CNT_W'(BURST_LEN));

  // Handshake and FIFO-side outputs; writes go straight through in the accept cycle.
  always_comb begin
    Req_ready = '0;
    if (w_busy && !Full) begin
      Req_ready[r_owner] = 1'b1;
    end
    Wr_enable = w_xfer;
    DataIn    = w_xfer ? w_owner_data : '0;
    Grant_id  = w_busy ? r_owner : '0;
    Busy      = w_busy;
  end

  // Burst FSM: grant in IDLE, count beats in BURST, freeze entirely while Full.
  always_ff @(posedge clk_write or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_last_owner <= IDX_W'(NUM_REQ - 1);
      r_count      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_owner <= w_pick;
            r_state <= BURST;
          end
        end
        BURST: begin
          if (!Full) begin
            if (w_xfer && !w_last_beat) begin
              r_count <= w_count_inc;
            end else begin
              // Either the final beat was taken or the owner ran dry.
              r_state      <= IDLE;
              r_last_owner <= r_owner;
              r_count      <= '0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter (4 requesters, 8-bit words, bursts of 4).
module tb_fifo_write_arbiter;

  localparam int NR = 4;
  localparam int BL = 4;

  logic        clk_write = 1'b0;
  logic        rst_n     = 1'b0;
  logic [3:0]  Req_valid = '0;
  logic [31:0] Req_data  = '0;
  logic [3:0]  Req_ready;
  logic        Full      = 1'b0;
  logic        Wr_enable;
  logic [7:0]  DataIn;
  logic [1:0]  Grant_id;
  logic        Busy;

  fifo_write_arbiter #(
    .DATA_WIDTH (8),
    .NUM_REQ    (4),
    .BURST_LEN  (4)
  ) dut (
    .clk_write (clk_write),
    .rst_n     (rst_n),
    .Req_valid (Req_valid),
    .Req_data  (Req_data),
    .Req_ready (Req_ready),
    .Full      (Full),
    .Wr_enable (Wr_enable),
    .DataIn    (DataIn),
    .Grant_id  (Grant_id),
    .Busy      (Busy)
  );

  always #5 clk_write = ~clk_write;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the FIFO, who owned it last, beats taken so far.
  int m_busy, m_owner, m_last, m_cnt;

  logic [7:0] sb_q[$];
  logic [7:0] wlog[$];

  logic       s_wr, s_busy;
  logic [1:0] s_gid;
  logic [3:0] s_ready;
  logic [7:0] s_data;

  typedef struct {
    logic [3:0] v;
    logic [7:0] d2;
    logic       f;
    logic       e_wr;
    logic       e_busy;
    logic [1:0] e_gid;
    logic [7:0] e_data;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] slice(input logic [31:0] d, input int k);
    return 8'(d >> (8 * k));
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_owner = 0;
    m_last  = NR - 1;
    m_cnt   = 0;
    sb_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk_write);
    rst_n     = 1'b0;
    Req_valid = '0;
    Req_data  = '0;
    Full      = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_write);
    rst_n = 1'b1;
  endtask

  // One clock: drive on the falling edge, check against the model, then advance the model.
  task automatic cycle(input logic [3:0] v, input logic [31:0] d, input logic f);
    logic       e_xfer;
    logic [3:0] e_ready;
    logic [7:0] w;
    @(negedge clk_write);
    Req_valid = v;
    Req_data  = d;
    Full      = f;
    #1;
    e_xfer  = (m_busy != 0) && v[m_owner[1:0]] && !f;
    e_ready = ((m_busy != 0) && !f) ? 4'(1 << m_owner) : 4'b0;
    chk("wr_enable", 32'(Wr_enable), 32'(e_xfer));
    chk("req_ready", 32'(Req_ready), 32'(e_ready));
    chk("data_in", 32'(DataIn), 32'(e_xfer ? slice(d, m_owner) : 8'h00));
    chk("grant_id", 32'(Grant_id), (m_busy != 0) ? 32'(m_owner) : 32'd0);
    chk("busy", 32'(Busy), 32'(m_busy));
    chk("ready_onehot", 32'($countones(Req_ready) <= 1), 32'd1);
    for (int k = 0; k < NR; k++) begin
      if (Req_ready[k] && v[k]) sb_q.push_back(slice(d, k));
    end
    if (Wr_enable) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_extra_write: got write %0h with no accepted word", DataIn);
      end else begin
        w = sb_q.pop_front();
        chk("sb_word", 32'(DataIn), 32'(w));
        wlog.push_back(DataIn);
      end
    end
    s_wr    = Wr_enable;
    s_busy  = Busy;
    s_gid   = Grant_id;
    s_ready = Req_ready;
    s_data  = DataIn;
    @(posedge clk_write);
    if (m_busy == 0) begin
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_last + k) % NR;
        if (v[c[1:0]]) begin
          m_owner = c;
          m_busy  = 1;
          break;
        end
      end
    end else if (!f) begin
      if (v[m_owner[1:0]]) begin
        m_cnt++;
        if (m_cnt == BL) begin
          m_busy = 0;
          m_last = m_owner;
          m_cnt  = 0;
        end
      end else begin
        m_busy = 0;
        m_last = m_owner;
        m_cnt  = 0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] words[4];
    logic [3:0] v;

    // Idle after reset, then requester 2 sends 55, 81 and drops.
    for (int i = 0; i < 5; i++) tbl[i] = '{4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
    tbl[5] = '{4'b0100, 8'h55, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
    tbl[6] = '{4'b0100, 8'h55, 1'b0, 1'b1, 1'b1, 2'd2, 8'h55};
    tbl[7] = '{4'b0100, 8'h81, 1'b0, 1'b1, 1'b1, 2'd2, 8'h81};
    tbl[8] = '{4'b0000, 8'h81, 1'b0, 1'b0, 1'b1, 2'd2, 8'h00};
    tbl[9] = '{4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};

    do_reset();
    wlog.delete();
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].v, {8'hA3, tbl[i].d2, 8'h17, 8'h9C}, tbl[i].f);
      chk("tbl_wr", 32'(s_wr), 32'(tbl[i].e_wr));
      chk("tbl_busy", 32'(s_busy), 32'(tbl[i].e_busy));
      chk("tbl_gid", 32'(s_gid), 32'(tbl[i].e_gid));
      chk("tbl_data", 32'(s_data), 32'(tbl[i].e_data));
    end
    chk("single_count", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("single_w0", 32'(wlog[0]), 32'h55);
      chk("single_w1", 32'(wlog[1]), 32'h81);
    end

    // Contention: bursts of 4 separated by one idle cycle, owners 0,1,2,3,0.
    do_reset();
    for (int c = 0; c < 25; c++) begin
      cycle(4'hF, $urandom, 1'b0);
      chk("cont_busy", 32'(s_busy), 32'((c % 5) != 0));
      chk("cont_wr", 32'(s_wr), 32'((c % 5) != 0));
      chk("cont_gid", 32'(s_gid), ((c % 5) != 0) ? 32'((c / 5) % 4) : 32'd0);
    end

    // Full stall after two writes, with a valid drop while stalled.
    do_reset();
    wlog.delete();
    words[0] = 8'hC1;
    words[1] = 8'h2D;
    words[2] = 8'h7E;
    words[3] = 8'hF0;
    cycle(4'b0010, {8'h11, 8'h22, words[0], 8'h33}, 1'b0);
    chk("stall_idle", 32'(s_busy), 32'd0);
    cycle(4'b0010, {8'h11, 8'h22, words[0], 8'h33}, 1'b0);
    cycle(4'b0010, {8'h11, 8'h22, words[1], 8'h33}, 1'b0);
    for (int c = 0; c < 6; c++) begin
      v = (c == 2 || c == 3) ? 4'b0000 : 4'b0010;
      cycle(v, {8'h11, 8'h22, words[2], 8'h33}, 1'b1);
      chk("stall_wr", 32'(s_wr), 32'd0);
      chk("stall_ready", 32'(s_ready), 32'd0);
      chk("stall_busy", 32'(s_busy), 32'd1);
      chk("stall_gid", 32'(s_gid), 32'd1);
    end
    cycle(4'b0010, {8'h11, 8'h22, words[2], 8'h33}, 1'b0);
    chk("resume_wr", 32'(s_wr), 32'd1);
    chk("resume_data", 32'(s_data), 32'(words[2]));
    cycle(4'b0010, {8'h11, 8'h22, words[3], 8'h33}, 1'b0);
    cycle(4'b0010, {8'h11, 8'h22, 8'h44, 8'h33}, 1'b0);
    chk("stall_end_idle", 32'(s_busy), 32'd0);
    chk("stall_count", 32'(wlog.size()), 32'd4);
    if (wlog.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("stall_order", 32'(wlog[i]), 32'(words[i]));
    end

    // Reset mid-burst: owner 3 has written once; reset must kill the write at once.
    do_reset();
    cycle(4'b1000, 32'h5A_00_00_00, 1'b0);
    cycle(4'b1000, 32'h5A_00_00_00, 1'b0);
    chk("mid_first_wr", 32'(s_wr), 32'd1);
    chk("mid_first_gid", 32'(s_gid), 32'd3);
    @(negedge clk_write);
    Req_valid = 4'b1000;
    Req_data  = 32'h6B_00_00_00;
    #1;
    chk("mid_pre_rst_wr", 32'(Wr_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr", 32'(Wr_enable), 32'd0);
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    chk("mid_rst_ready", 32'(Req_ready), 32'd0);
    chk("mid_rst_data", 32'(DataIn), 32'd0);
    chk("mid_rst_gid", 32'(Grant_id), 32'd0);
    Req_valid = '0;
    model_reset();
    repeat (2) @(negedge clk_write);
    rst_n = 1'b1;
    cycle(4'hF, 32'hDD_CC_BB_AA, 1'b0);
    chk("post_rst_idle", 32'(s_busy), 32'd0);
    cycle(4'hF, 32'hDD_CC_BB_AA, 1'b0);
    chk("post_rst_gid", 32'(s_gid), 32'd0);
    chk("post_rst_data", 32'(s_data), 32'hAA);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      cycle(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 4) == 0));
    end
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of each requester data word and of DataIn.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (range 2..8).
REQ-003 The block SHALL have parameter BURST_LEN, default 4, giving the maximum words per grant (range 1..16).
REQ-004 clk_write  input  1  single clock (FIFO write-side clock); all state on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Req_valid  input  NUM_REQ  per-requester word-available flag.
REQ-007 Req_data  input  NUM_REQ*DATA_WIDTH  packed words; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Req_ready  output  NUM_REQ  per-requester accept strobe, at most one bit set.
REQ-009 Full  input  1  FIFO full flag, write-clock domain.
REQ-010 Wr_enable  output  1  FIFO write enable.
REQ-011 DataIn  output  DATA_WIDTH  FIFO write data.
REQ-012 Grant_id  output  clog2(NUM_REQ)  index of the current owner; 0 when idle.
REQ-013 Busy  output  1  high while a burst is owned.

Function
REQ-014 The block SHALL implement states IDLE and BURST.
REQ-015 In IDLE with any Req_valid set, the block SHALL pick the owner round-robin, searching from last_owner+1 with wrap-around modulo NUM_REQ, and enter BURST on the next edge; IDLE SHALL never assert Req_ready or Wr_enable.
REQ-016 In BURST, Req_ready[owner] SHALL equal !Full combinationally, and all other Req_ready bits SHALL be 0.
REQ-017 A transfer SHALL occur in any cycle with Req_valid[owner] and Req_ready[owner] both high.
REQ-018 Wr_enable SHALL equal the transfer condition combinationally, and DataIn SHALL equal owner's Req_data slice, so FIFO write latency is zero cycles after acceptance.
REQ-019 In a non-transfer cycle, DataIn SHALL hold 0.
REQ-020 A burst counter SHALL count transfers from 0.
REQ-021 BURST SHALL return to IDLE on the edge after the BURST_LEN-th transfer.
REQ-022 BURST SHALL also return to IDLE on any edge where Req_valid[owner] is low and Full is low (owner ran dry).
REQ-023 On every return to IDLE, last_owner SHALL be updated to owner and the counter cleared.
REQ-024 While Full is high, BURST SHALL hold state, counter and owner regardless of Req_valid, with no transfer.
REQ-025 Full rising in the same cycle as a pending word SHALL block that word, and the word SHALL be written in the first cycle Full is low.
REQ-026 A requester dropping Req_valid while Full is high SHALL NOT end the burst until Full clears.
REQ-027 The minimum gap between bursts SHALL be one IDLE cycle, giving peak throughput BURST_LEN words per BURST_LEN+1 cycles under contention.
REQ-028 Busy SHALL be high exactly in BURST, and Grant_id SHALL show owner in BURST.

Reset
REQ-029 Asserting rst_n low SHALL immediately force IDLE, owner 0, last_owner NUM_REQ-1 (so requester 0 wins first), counter 0, Wr_enable 0, Req_ready 0, DataIn 0, Grant_id 0 and Busy 0.
REQ-030 Reset asserted mid-burst SHALL abandon the burst with no further write, and no partial state SHALL survive.
REQ-031 Reset deassertion SHALL take effect on the first clk_write edge after release.

Structure
REQ-032 Shared package fifo_arb_pkg SHALL hold the state enum (IDLE, BURST) and the default DATA_WIDTH, NUM_REQ and BURST_LEN constants.
REQ-033 Round-robin selection SHALL live in a sub-module rr_pick (inputs request vector and last index; output found flag and index), which is combinational.
REQ-034 All other logic SHALL stay in fifo_write_arbiter, with state registers only for state, owner, last_owner and counter.

Verification
REQ-035 Reset test: after reset, with Req_valid=4'b0000 -> Wr_enable=0, Busy=0, Grant_id=0 for 5 cycles.
REQ-036 Single requester: Req_valid[2]=1 with data 8'h55,8'h81 then drops -> Grant_id=2, FIFO receives 55,81, back to IDLE one edge after drop.
REQ-037 Contention: all 4 valid continuously, BURST_LEN=4 -> owners 0,1,2,3,0 with 4 writes each, one idle cycle between bursts.
REQ-038 Full stall: Full=1 for 6 cycles mid-burst after 2 writes -> no Wr_enable, no Req_ready, owner held; remaining 2 words written after Full clears, order preserved.
REQ-039 Reset mid-burst: rst_n low after 1 write of 4 -> Wr_enable falls immediately; after release, requester 0 granted first.
REQ-040 Scoreboard on all tests: each FIFO-side word equals the accepted requester word, no duplicates or drops, and at most one Req_ready bit is set per cycle.
